// File: rtl/piano_pkg.sv
// Shared types for the PS/2 piano front end: note type, special scancodes,
// parser states and the scancode-to-note lookup.
package piano_pkg;

    localparam int NUM_NOTES  = 24;
    localparam int PKG_NOTE_W = 5;

    typedef logic [PKG_NOTE_W-1:0] note_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        PS_IDLE      = 2'd0,
        PS_BREAK     = 2'd1,
        PS_EXT       = 2'd2,
        PS_EXT_BREAK = 2'd3
    } parse_state_t;

    typedef struct packed {
        logic  hit;
        note_t note;
    } key_map_t;

    // Two octaves laid out over the Q..P, A..L and Z..B letter rows.
    function automatic key_map_t map_scancode(input logic [7:0] sc);
        key_map_t m;
        m.hit  = 1'b1;
        m.note = '0;
        case (sc)
            8'h15: m.note = 5'd0;
            8'h1D: m.note = 5'd1;
            8'h24: m.note = 5'd2;
            8'h2D: m.note = 5'd3;
            8'h2C: m.note = 5'd4;
            8'h35: m.note = 5'd5;
            8'h3C: m.note = 5'd6;
            8'h43: m.note = 5'd7;
            8'h44: m.note = 5'd8;
            8'h4D: m.note = 5'd9;
            8'h1C: m.note = 5'd10;
            8'h1B: m.note = 5'd11;
            8'h23: m.note = 5'd12;
            8'h2B: m.note = 5'd13;
            8'h34: m.note = 5'd14;
            8'h33: m.note = 5'd15;
            8'h3B: m.note = 5'd16;
            8'h42: m.note = 5'd17;
            8'h4B: m.note = 5'd18;
            8'h1A: m.note = 5'd19;
            8'h22: m.note = 5'd20;
            8'h21: m.note = 5'd21;
            8'h2A: m.note = 5'd22;
            8'h32: m.note = 5'd23;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_scancode_parser.sv
// Turns the raw PS/2 byte stream into registered make/break note events;
// extended (E0-prefixed) sequences are swallowed without an event.
module ps2_scancode_parser
    import piano_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    input  logic       all_off,
    output logic       ev_valid,
    output logic       ev_make,
    output note_t      ev_note
);

    parse_state_t state_reg, state_next;
    logic         ev_valid_reg, ev_valid_next;
    logic         ev_make_reg, ev_make_next;
    note_t        ev_note_reg, ev_note_next;
    key_map_t     map;

    assign map = map_scancode(ps2_key_data);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= PS_IDLE;
            ev_valid_reg <= 1'b0;
            ev_make_reg  <= 1'b0;
            ev_note_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ev_valid_reg <= ev_valid_next;
            ev_make_reg  <= ev_make_next;
            ev_note_reg  <= ev_note_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ev_valid_next = 1'b0;
        ev_make_next  = ev_make_reg;
        ev_note_next  = ev_note_reg;
        if (ps2_key_pressed) begin
            case (state_reg)
                PS_IDLE: begin
                    if (ps2_key_data == SC_BREAK) begin
                        state_next = PS_BREAK;
                    end else if (ps2_key_data == SC_EXT) begin
                        state_next = PS_EXT;
                    end else if (map.hit) begin
                        ev_valid_next = 1'b1;
                        ev_make_next  = 1'b1;
                        ev_note_next  = map.note;
                    end
                end
                PS_BREAK: begin
                    state_next = PS_IDLE;
                    if (map.hit) begin
                        ev_valid_next = 1'b1;
                        ev_make_next  = 1'b0;
                        ev_note_next  = map.note;
                    end
                end
                PS_EXT: begin
                    state_next = (ps2_key_data == SC_BREAK) ? PS_EXT_BREAK : PS_IDLE;
                end
                default: begin
                    state_next = PS_IDLE;
                end
            endcase
        end
        // Panic drops the event but the byte still steers the parser.
        if (all_off) begin
            ev_valid_next = 1'b0;
        end
    end

    assign ev_valid = ev_valid_reg;
    assign ev_make  = ev_make_reg;
    assign ev_note  = ev_note_reg;

endmodule

// File: rtl/ps2_voice_allocator.sv
// PS/2 piano key tracker sharing NUM_VOICES tone voices among 24 notes.
// Define VOICE_STEAL_EN to steal the oldest voice when all are busy.
module ps2_voice_allocator
    import piano_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 5
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic [7:0]                   ps2_key_data,
    input  logic                         ps2_key_pressed,
    input  logic                         all_off,
    output logic [NUM_NOTES-1:0]         key_held,
    output logic [NUM_NOTES-1:0]         note_on,
    output logic [NUM_VOICES-1:0]        voice_valid,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic                         overflow
);

    localparam int AGE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    logic              ev_valid;
    logic              ev_make;
    note_t             ev_note;
    logic [NOTE_W-1:0] ev_note_w;

    ps2_scancode_parser u_parser (
        .CLOCK_50        (CLOCK_50),
        .resetn          (resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .all_off         (all_off),
        .ev_valid        (ev_valid),
        .ev_make         (ev_make),
        .ev_note         (ev_note)
    );

    assign ev_note_w = NOTE_W'(ev_note);

    logic [NUM_NOTES-1:0]  key_held_reg, key_held_next;
    logic [NUM_VOICES-1:0] valid_reg, valid_next;
    logic [NOTE_W-1:0]     note_reg [NUM_VOICES];
    logic [NOTE_W-1:0]     note_next [NUM_VOICES];
    logic [AGE_W-1:0]      age_reg [NUM_VOICES];
    logic [AGE_W-1:0]      age_next [NUM_VOICES];
    logic                  overflow_reg, overflow_next;

    logic                  free_found;
    logic [NUM_VOICES-1:0] free_sel;
    logic [NUM_VOICES-1:0] alloc_sel;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_held_reg <= '0;
            valid_reg    <= '0;
            overflow_reg <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_reg[v] <= '0;
                age_reg[v]  <= '0;
            end
        end else begin
            key_held_reg <= key_held_next;
            valid_reg    <= valid_next;
            overflow_reg <= overflow_next;
            note_reg     <= note_next;
            age_reg      <= age_next;
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_sel   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!valid_reg[v] && !free_found) begin
                free_found  = 1'b1;
                free_sel[v] = 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]      best_age;
    logic [AGE_W-1:0]      best_idx;
    logic [NUM_VOICES-1:0] oldest_sel;

    // Strict compare keeps the lowest index on equal ages.
    always_comb begin
        best_age = age_reg[0];
        best_idx = '0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_reg[v] > best_age) begin
                best_age = age_reg[v];
                best_idx = AGE_W'(v);
            end
        end
        oldest_sel = NUM_VOICES'(1) << best_idx;
    end
`endif

    always_comb begin
        key_held_next = key_held_reg;
        valid_next    = valid_reg;
        note_next     = note_reg;
        age_next      = age_reg;
        overflow_next = 1'b0;
        alloc_sel     = '0;
        if (all_off) begin
            key_held_next = '0;
            valid_next    = '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                age_next[v] = '0;
            end
        end else if (ev_valid) begin
            if (ev_make) begin
                if (!key_held_reg[ev_note_w]) begin
                    key_held_next[ev_note_w] = 1'b1;
                    if (free_found) begin
                        alloc_sel = free_sel;
                    end else begin
`ifdef VOICE_STEAL_EN
                        alloc_sel = oldest_sel;
`else
                        overflow_next = 1'b1;
`endif
                    end
                end
            end else if (key_held_reg[ev_note_w]) begin
                key_held_next[ev_note_w] = 1'b0;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (valid_reg[v] && note_reg[v] == ev_note_w) begin
                        valid_next[v] = 1'b0;
                    end
                end
            end
        end
        if (alloc_sel != '0) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (alloc_sel[v]) begin
                    valid_next[v] = 1'b1;
                    note_next[v]  = ev_note_w;
                    age_next[v]   = '0;
                end else if (valid_reg[v] && age_reg[v] != AGE_MAX) begin
                    age_next[v] = age_reg[v] + 1'b1;
                end
            end
        end
    end

    logic [NUM_NOTES-1:0] voice_hot [NUM_VOICES];
    logic [NUM_NOTES-1:0] note_on_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign voice_note[gi*NOTE_W +: NOTE_W] = note_reg[gi];
            assign voice_hot[gi] = valid_reg[gi] ? (NUM_NOTES'(1) << note_reg[gi]) : '0;
        end
    endgenerate

    always_comb begin
        note_on_w = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            note_on_w = note_on_w | voice_hot[v];
        end
    end

    assign key_held    = key_held_reg;
    assign note_on     = note_on_w;
    assign voice_valid = valid_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Bench for ps2_voice_allocator: directed scenarios plus randomized byte
// streams checked against a per-cycle behavioural model.
module tb_ps2_voice_allocator;

    localparam int NV = 4;
    localparam int NW = 5;

    logic              CLOCK_50 = 1'b0;
    logic              resetn = 1'b0;
    logic [7:0]        ps2_key_data = 8'h00;
    logic              ps2_key_pressed = 1'b0;
    logic              all_off = 1'b0;
    logic [23:0]       key_held;
    logic [23:0]       note_on;
    logic [NV-1:0]     voice_valid;
    logic [NV*NW-1:0]  voice_note;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    bit ovf_seen;

    logic [7:0] keymap [24] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                                8'h44, 8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33,
                                8'h3B, 8'h42, 8'h4B, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32};

    ps2_voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
        .CLOCK_50        (CLOCK_50),
        .resetn          (resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .all_off         (all_off),
        .key_held        (key_held),
        .note_on         (note_on),
        .voice_valid     (voice_valid),
        .voice_note      (voice_note),
        .overflow        (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: parser mode 0 idle, 1 after F0, 2 after E0, 3 after E0 F0.
    int          m_ps;
    bit          pv, pm;
    int          pn;
    bit [23:0]   m_held;
    bit          m_vv [NV];
    int          m_vn [NV];
    int          m_age [NV];
    bit          m_ovf;

    function automatic int note_of(logic [7:0] b);
        for (int i = 0; i < 24; i++) if (keymap[i] == b) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_ps = 0; pv = 0; pm = 0; pn = 0; m_held = '0; m_ovf = 0;
        for (int v = 0; v < NV; v++) begin
            m_vv[v] = 0; m_vn[v] = 0; m_age[v] = 0;
        end
    endfunction

    function automatic void model_step(bit s, logic [7:0] d, bit ao);
        int n;
        int fv;
        m_ovf = 0;
        if (ao) begin
            m_held = '0;
            for (int v = 0; v < NV; v++) m_vv[v] = 0;
        end else if (pv) begin
            if (pm) begin
                if (!m_held[pn]) begin
                    m_held[pn] = 1;
                    fv = -1;
                    for (int v = 0; v < NV; v++) if (!m_vv[v] && fv < 0) fv = v;
`ifdef VOICE_STEAL_EN
                    if (fv < 0) begin
                        fv = 0;
                        for (int v = 1; v < NV; v++) if (m_age[v] > m_age[fv]) fv = v;
                    end
`endif
                    if (fv < 0) begin
                        m_ovf = 1;
                    end else begin
                        for (int v = 0; v < NV; v++)
                            if (v != fv && m_vv[v] && m_age[v] < NV - 1) m_age[v] = m_age[v] + 1;
                        m_vv[fv] = 1; m_vn[fv] = pn; m_age[fv] = 0;
                    end
                end
            end else if (m_held[pn]) begin
                m_held[pn] = 0;
                for (int v = 0; v < NV; v++) if (m_vv[v] && m_vn[v] == pn) m_vv[v] = 0;
            end
        end
        pv = 0;
        if (s) begin
            n = note_of(d);
            case (m_ps)
                0: begin
                    if (d == 8'hF0) m_ps = 1;
                    else if (d == 8'hE0) m_ps = 2;
                    else if (n >= 0) begin pv = 1; pm = 1; pn = n; end
                end
                1: begin
                    m_ps = 0;
                    if (n >= 0) begin pv = 1; pm = 0; pn = n; end
                end
                2: m_ps = (d == 8'hF0) ? 3 : 0;
                default: m_ps = 0;
            endcase
            if (ao) pv = 0;
        end
    endfunction

    task automatic drive_cycle(input bit s, input logic [7:0] d, input bit ao);
        ps2_key_pressed = s;
        ps2_key_data    = d;
        all_off         = ao;
        @(posedge CLOCK_50);
        model_step(s, d, ao);
        #1;
        ps2_key_pressed = 1'b0;
        all_off         = 1'b0;
        if (overflow === 1'b1) ovf_seen = 1;
    endtask

    task automatic send(input logic [7:0] d);
        $display("tx byte %h", d);
        drive_cycle(1'b1, d, 1'b0);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;
        ovf_seen = 0;
    endtask

    task automatic test_reset();
        do_reset();
        send(8'h15);
        idle();
        send(8'hF0);
        resetn = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if (key_held !== 24'h0 || note_on !== 24'h0 || voice_valid !== '0 ||
            voice_note !== '0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: held=%h on=%h vv=%b vn=%h ovf=%b, required all 0",
                     key_held, note_on, voice_valid, voice_note, overflow);
        end
        @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;
        send(8'h15);
        idle();
        n_cmp++;
        if (key_held !== 24'h000001 || voice_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_parser_idle: held=%h vv=%b, required 000001 0001", key_held, voice_valid);
        end
        send(8'h1D);
        resetn = 1'b0;
        model_reset();
        #2;
        resetn = 1'b1;
        idle();
        idle();
        n_cmp++;
        if (key_held !== 24'h0 || voice_valid !== '0) begin
            n_err++;
            $display("FAIL reset_abort_event: held=%h vv=%b, required 0 0", key_held, voice_valid);
        end
    endtask

    task automatic test_make_break();
        do_reset();
        send(8'h15);
        n_cmp++;
        if (voice_valid !== '0) begin
            n_err++;
            $display("FAIL make_latency_n1: vv=%b, required 0000", voice_valid);
        end
        idle();
        n_cmp++;
        if (voice_valid !== 4'b0001 || voice_note[4:0] !== 5'd0 || note_on !== 24'h1 || key_held !== 24'h1) begin
            n_err++;
            $display("FAIL make_n2: vv=%b vn0=%0d on=%h held=%h, required 0001 0 000001 000001",
                     voice_valid, voice_note[4:0], note_on, key_held);
        end
        send(8'hF0);
        send(8'h15);
        idle();
        n_cmp++;
        if (voice_valid !== '0 || key_held !== 24'h0 || note_on !== 24'h0) begin
            n_err++;
            $display("FAIL break: vv=%b held=%h on=%h, required 0 0 0", voice_valid, key_held, note_on);
        end
    endtask

    task automatic test_repeat_ext();
        do_reset();
        send(8'h1D);
        send(8'h1D);
        send(8'h1D);
        idle();
        n_cmp++;
        if (voice_valid !== 4'b0001 || voice_note[4:0] !== 5'd1 || key_held !== 24'h2 || ovf_seen) begin
            n_err++;
            $display("FAIL repeat: vv=%b vn0=%0d held=%h ovf_seen=%0d, required 0001 1 000002 0",
                     voice_valid, voice_note[4:0], key_held, ovf_seen);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h1D);
        idle();
        n_cmp++;
        if (voice_valid !== 4'b0001 || note_on !== 24'h2 || key_held !== 24'h2) begin
            n_err++;
            $display("FAIL ext_ignored: vv=%b on=%h held=%h, required 0001 000002 000002",
                     voice_valid, note_on, key_held);
        end
    endtask

    task automatic test_full_voices();
        do_reset();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        idle();
`ifdef VOICE_STEAL_EN
        n_cmp++;
        if (note_on !== 24'h00001E || voice_note[4:0] !== 5'd4 || voice_valid !== 4'hF || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL steal: on=%h vn0=%0d vv=%b ovf=%b, required 00001e 4 1111 0",
                     note_on, voice_note[4:0], voice_valid, overflow);
        end
        idle();
        n_cmp++;
        if (ovf_seen || key_held !== 24'h00001F) begin
            n_err++;
            $display("FAIL steal_held: ovf_seen=%0d held=%h, required 0 00001f", ovf_seen, key_held);
        end
`else
        n_cmp++;
        if (overflow !== 1'b1 || note_on !== 24'h00000F || key_held !== 24'h00001F) begin
            n_err++;
            $display("FAIL overflow: ovf=%b on=%h held=%h, required 1 00000f 00001f",
                     overflow, note_on, key_held);
        end
        idle();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_pulse: ovf=%b, required 0", overflow);
        end
`endif
    endtask

    task automatic test_all_off();
        bit note2_seen;
        do_reset();
        send(8'h15);
        send(8'h1D);
        idle();
        n_cmp++;
        if (key_held !== 24'h3) begin
            n_err++;
            $display("FAIL all_off_pre: held=%h, required 000003", key_held);
        end
        drive_cycle(1'b1, 8'h24, 1'b1);
        note2_seen = note_on[2];
        n_cmp++;
        if (key_held !== 24'h0 || voice_valid !== '0) begin
            n_err++;
            $display("FAIL all_off_clear: held=%h vv=%b, required 0 0", key_held, voice_valid);
        end
        idle();
        note2_seen = note2_seen | note_on[2];
        idle();
        note2_seen = note2_seen | note_on[2];
        n_cmp++;
        if (note2_seen || key_held !== 24'h0 || voice_valid !== '0) begin
            n_err++;
            $display("FAIL all_off_discard: note2_seen=%0d held=%h vv=%b, required 0 0 0",
                     note2_seen, key_held, voice_valid);
        end
    endtask

    task automatic test_unmapped();
        do_reset();
        send(8'h15);
        send(8'h5A);
        send(8'hF0);
        send(8'h5A);
        send(8'hF0);
        send(8'h32);
        idle();
        n_cmp++;
        if (key_held !== 24'h1 || note_on !== 24'h1 || voice_valid !== 4'b0001 || ovf_seen) begin
            n_err++;
            $display("FAIL unmapped: held=%h on=%h vv=%b ovf_seen=%0d, required 000001 000001 0001 0",
                     key_held, note_on, voice_valid, ovf_seen);
        end
    endtask

    task automatic test_random();
        logic [7:0]       pool [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h32};
        logic [23:0]      exp_on;
        logic [NV-1:0]    exp_vv;
        logic [NV*NW-1:0] exp_vn;
        logic [7:0]       d;
        bit               s, ao, prev_s;
        int               r;
        do_reset();
        prev_s = 0;
        for (int c = 0; c < 500; c++) begin
            s  = ($urandom_range(0, 9) < 6);
            ao = 0;
            r  = $urandom_range(0, 19);
            if (r < 9)       d = pool[$urandom_range(0, 7)];
            else if (r < 15) d = 8'hF0;
            else if (r < 16) d = 8'hE0;
            else if (r < 18) d = keymap[$urandom_range(0, 23)];
            else             d = 8'($urandom);
            if (!s && !prev_s && $urandom_range(0, 29) == 0) ao = 1;
            if (s) $display("rnd cycle %0d byte %h", c, d);
            drive_cycle(s, d, ao);
            prev_s = s;
            exp_on = '0;
            for (int v = 0; v < NV; v++) begin
                exp_vv[v] = m_vv[v];
                exp_vn[v*NW +: NW] = NW'(m_vn[v]);
                if (m_vv[v]) exp_on[m_vn[v]] = 1'b1;
            end
            n_cmp++;
            if (key_held !== m_held || note_on !== exp_on || voice_valid !== exp_vv ||
                voice_note !== exp_vn || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL random c%0d: held=%h on=%h vv=%b vn=%h ovf=%b, required %h %h %b %h %b",
                         c, key_held, note_on, voice_valid, voice_note, overflow,
                         m_held, exp_on, exp_vv, exp_vn, m_ovf);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_break();
        test_repeat_ext();
        test_full_voices();
        test_all_off();
        test_unmapped();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
